dcache_way_sram: RTL and testbench

DCACHE_WAY_SRAM -- requirements
Module: dcache_way_sram

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_lru.sv | 58 +++++
 rtl/dcache_way_sram.sv | 247 ++++++++++++++++++++++++
 tb/tb_dcache_way_sram.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and defaults for the data-cache way array.
// Holds size defaults, derived widths, request precedence and flush states.
package dcache_pkg;

  localparam int DC_WAYS        = 2;
  localparam int DC_SETS        = 2;
  localparam int DC_TAG_W       = 3;
  localparam int DC_BLOCK_BYTES = 4;

  localparam int DC_SET_W      = $clog2(DC_SETS);
  localparam int DC_WAY_W      = $clog2(DC_WAYS);
  localparam int DC_BLOCK_BITS = 8 * DC_BLOCK_BYTES;

  // Winning request after precedence memWen > wen > ren.
  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_RD,
    REQ_WR,
    REQ_FILL
  } req_e;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_SCAN,
    FL_WB_WAIT,
    FL_DONE
  } flush_st_e;

endpackage

// File: rtl/dcache_lru.sv
// Per-set age-based LRU state and victim selection.
// Ports: clk, rst (async low), i_upd/i_set/i_way touch, i_valid set valids, o_victim.
module dcache_lru
  import dcache_pkg::*;
#(
  parameter int WAYS  = DC_WAYS,
  parameter int SETS  = DC_SETS,
  parameter int SET_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_upd,
  input  logic [SET_W-1:0] i_set,
  input  logic [WAY_W-1:0] i_way,
  input  logic [WAYS-1:0]  i_valid,
  output logic [WAY_W-1:0] o_victim
);

  logic [WAY_W-1:0] r_age [SETS][WAYS];
  logic [WAY_W-1:0] w_old;
  logic             w_found;

  assign w_old = r_age[i_set][i_way];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          r_age[s][w] <= WAY_W'(w);
    end else if (i_upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == i_way)
          r_age[i_set][w] <= '0;
        else if (r_age[i_set][w] < w_old)
          r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
      end
    end
  end

  // Lowest invalid way wins; otherwise the oldest way.
  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !i_valid[w]) begin
        o_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++)
        if (r_age[i_set][w] == WAY_W'(WAYS - 1))
          o_victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dcache_way_sram.sv
// Set-associative data-cache tag/data array with LRU and optional flush.
// Ports: lookup (ren/wen/memWen/bytesAccess/blockAddr/dataIn -> hit/dirtyBit/
// dataOut/victimAddr), flush (flushReq/flushBusy/flushDone), write-back
// channel (wbValid/wbReady/wbAddr/wbData). Flush FSM under DCACHE_FLUSH_EN.
module dcache_way_sram
  import dcache_pkg::*;
#(
  parameter int WAYS        = DC_WAYS,
  parameter int SETS        = DC_SETS,
  parameter int TAG_W       = DC_TAG_W,
  parameter int BLOCK_BYTES = DC_BLOCK_BYTES,
  localparam int SET_W      = $clog2(SETS),
  localparam int WAY_W      = $clog2(WAYS),
  localparam int BLOCK_BITS = 8 * BLOCK_BYTES,
  localparam int ADDR_W     = TAG_W + SET_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ren,
  input  logic                   wen,
  input  logic                   memWen,
  input  logic [BLOCK_BYTES-1:0] bytesAccess,
  input  logic [ADDR_W-1:0]      blockAddr,
  input  logic [BLOCK_BITS-1:0]  dataIn,
  output logic                   hit,
  output logic                   dirtyBit,
  output logic [BLOCK_BITS-1:0]  dataOut,
  output logic [ADDR_W-1:0]      victimAddr,
  input  logic                   flushReq,
  output logic                   flushBusy,
  output logic                   flushDone,
  output logic                   wbValid,
  input  logic                   wbReady,
  output logic [ADDR_W-1:0]      wbAddr,
  output logic [BLOCK_BITS-1:0]  wbData
);

  logic                  r_valid [SETS][WAYS];
  logic                  r_dirty [SETS][WAYS];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [BLOCK_BITS-1:0] r_data  [SETS][WAYS];

  logic [TAG_W-1:0] w_tag;
  logic [SET_W-1:0] w_set;
  logic             w_hit;
  logic [WAY_W-1:0] w_hway;
  logic [WAY_W-1:0] w_victim;
  logic [WAY_W-1:0] w_fway;
  logic [WAYS-1:0]  w_vvec;
  logic             w_busy;
  logic             w_upd;
  logic [WAY_W-1:0] w_uway;
  req_e             w_req;

  logic             w_fl_clr;
  logic [SET_W-1:0] w_fl_set;
  logic [WAY_W-1:0] w_fl_way;

  assign w_tag = blockAddr[ADDR_W-1:SET_W];
  assign w_set = blockAddr[SET_W-1:0];

  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    w_vvec = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_vvec[w] = r_valid[w_set][w];
      if (r_valid[w_set][w] && r_tag[w_set][w] == w_tag) begin
        w_hit  = 1'b1;
        w_hway = WAY_W'(w);
      end
    end
  end

  // Overlapping requests are legal; first match wins.
  always_comb begin
    w_req = REQ_NONE;
    if (!w_busy) begin
      priority case (1'b1)
        memWen:  w_req = REQ_FILL;
        wen:     w_req = REQ_WR;
        ren:     w_req = REQ_RD;
        default: w_req = REQ_NONE;
      endcase
    end
  end

  // A fill of a resident tag refreshes that way instead of evicting.
  assign w_fway = w_hit ? w_hway : w_victim;
  assign w_upd  = (w_req == REQ_FILL) ||
                  ((w_req == REQ_RD || w_req == REQ_WR) && w_hit);
  assign w_uway = (w_req == REQ_FILL) ? w_fway : w_hway;

  dcache_lru #(
    .WAYS  (WAYS),
    .SETS  (SETS),
    .SET_W (SET_W),
    .WAY_W (WAY_W)
  ) u_lru (
    .clk      (clk),
    .rst      (rst),
    .i_upd    (w_upd),
    .i_set    (w_set),
    .i_way    (w_uway),
    .i_valid  (w_vvec),
    .o_victim (w_victim)
  );

  always_ff @(posedge clk) begin
    if (w_req == REQ_FILL) begin
      r_data[w_set][w_fway] <= dataIn;
    end else if (w_req == REQ_WR && w_hit) begin
      for (int b = 0; b < BLOCK_BYTES; b++)
        if (bytesAccess[b])
          r_data[w_set][w_hway][8*b +: 8] <= dataIn[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
        end
      hit        <= 1'b0;
      dirtyBit   <= 1'b0;
      dataOut    <= '0;
      victimAddr <= '0;
    end else begin
      if (w_fl_clr)
        r_dirty[w_fl_set][w_fl_way] <= 1'b0;
      unique case (w_req)
        REQ_FILL: begin
          r_valid[w_set][w_fway] <= 1'b1;
          r_dirty[w_set][w_fway] <= 1'b0;
          r_tag[w_set][w_fway]   <= w_tag;
          hit        <= 1'b0;
          dirtyBit   <= 1'b0;
          dataOut    <= '0;
          victimAddr <= '0;
        end
        REQ_WR, REQ_RD: begin
          if (w_hit) begin
            if (w_req == REQ_WR)
              r_dirty[w_set][w_hway] <= 1'b1;
            hit        <= 1'b1;
            dirtyBit   <= 1'b0;
            dataOut    <= (w_req == REQ_RD) ?
                          r_data[w_set][w_hway] : '0;
            victimAddr <= '0;
          end else begin
            hit        <= 1'b0;
            dirtyBit   <= r_dirty[w_set][w_victim];
            dataOut    <= '0;
            victimAddr <= {r_tag[w_set][w_victim], w_set};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_FLUSH_EN
  flush_st_e              r_fst;
  flush_st_e              w_fst_nxt;
  logic [SET_W+WAY_W-1:0] r_fptr;
  logic [SET_W+WAY_W-1:0] w_fptr_nxt;
  logic                   w_last;
  logic                   w_ent_dirty;

  // Pointer is {set, way}, so +1 walks set-major, way-minor.
  assign w_fl_set    = r_fptr[SET_W+WAY_W-1:WAY_W];
  assign w_fl_way    = r_fptr[WAY_W-1:0];
  assign w_last      = &r_fptr;
  assign w_ent_dirty = r_valid[w_fl_set][w_fl_way] &&
                       r_dirty[w_fl_set][w_fl_way];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fst  <= FL_IDLE;
      r_fptr <= '0;
    end else begin
      r_fst  <= w_fst_nxt;
      r_fptr <= w_fptr_nxt;
    end
  end

  always_comb begin
    w_fst_nxt  = r_fst;
    w_fptr_nxt = r_fptr;
    w_fl_clr   = 1'b0;
    unique case (r_fst)
      FL_IDLE: begin
        if (flushReq) begin
          w_fst_nxt  = FL_SCAN;
          w_fptr_nxt = '0;
        end
      end
      FL_SCAN: begin
        if (w_ent_dirty)
          w_fst_nxt = FL_WB_WAIT;
        else if (w_last)
          w_fst_nxt = FL_DONE;
        else
          w_fptr_nxt = r_fptr + 1'b1;
      end
      FL_WB_WAIT: begin
        if (wbReady) begin
          w_fl_clr = 1'b1;
          if (w_last) begin
            w_fst_nxt = FL_DONE;
          end else begin
            w_fst_nxt  = FL_SCAN;
            w_fptr_nxt = r_fptr + 1'b1;
          end
        end
      end
      FL_DONE: w_fst_nxt = FL_IDLE;
      default: w_fst_nxt = FL_IDLE;
    endcase
  end

  assign w_busy    = (r_fst != FL_IDLE);
  assign flushBusy = w_busy;
  assign flushDone = (r_fst == FL_DONE);
  assign wbValid   = (r_fst == FL_WB_WAIT);
  assign wbAddr    = wbValid ?
                     {r_tag[w_fl_set][w_fl_way], w_fl_set} : '0;
  assign wbData    = wbValid ? r_data[w_fl_set][w_fl_way] : '0;
`else
  logic w_unused;

  assign w_unused  = ^{flushReq, wbReady};
  assign w_busy    = 1'b0;
  assign w_fl_clr  = 1'b0;
  assign w_fl_set  = '0;
  assign w_fl_way  = '0;
  assign flushBusy = 1'b0;
  assign flushDone = 1'b0;
  assign wbValid   = 1'b0;
  assign wbAddr    = '0;
  assign wbData    = '0;
`endif

endmodule

// File: tb/tb_dcache_way_sram.sv
// Directed-vector bench for dcache_way_sram at default sizes.
// Flush scenarios run only when DCACHE_FLUSH_EN is defined.
module tb_dcache_way_sram;

  logic        clk;
  logic        rst;
  logic        ren;
  logic        wen;
  logic        memWen;
  logic [3:0]  bytesAccess;
  logic [3:0]  blockAddr;
  logic [31:0] dataIn;
  logic        hit;
  logic        dirtyBit;
  logic [31:0] dataOut;
  logic [3:0]  victimAddr;
  logic        flushReq;
  logic        flushBusy;
  logic        flushDone;
  logic        wbValid;
  logic        wbReady;
  logic [3:0]  wbAddr;
  logic [31:0] wbData;

  int n_vec = 0;
  int n_err = 0;

  dcache_way_sram dut (
    .clk         (clk),
    .rst         (rst),
    .ren         (ren),
    .wen         (wen),
    .memWen      (memWen),
    .bytesAccess (bytesAccess),
    .blockAddr   (blockAddr),
    .dataIn      (dataIn),
    .hit         (hit),
    .dirtyBit    (dirtyBit),
    .dataOut     (dataOut),
    .victimAddr  (victimAddr),
    .flushReq    (flushReq),
    .flushBusy   (flushBusy),
    .flushDone   (flushDone),
    .wbValid     (wbValid),
    .wbReady     (wbReady),
    .wbAddr      (wbAddr),
    .wbData      (wbData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic r, input logic w, input logic m,
                     input logic [3:0] be, input logic [3:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    ren = r; wen = w; memWen = m;
    bytesAccess = be; blockAddr = a; dataIn = d;
    cyc();
    ren = 1'b0; wen = 1'b0; memWen = 1'b0;
  endtask

  task automatic wait_wb();
    for (int k = 0; k < 20; k++) begin
      if (wbValid) break;
      cyc();
    end
    chk("wb_wait_to", wbValid, 1);
  endtask

  initial begin
    int n_done;
    logic [3:0]  a0;
    logic [31:0] d0;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; memWen = 1'b0;
    bytesAccess = '0; blockAddr = '0; dataIn = '0;
    flushReq = 1'b0; wbReady = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_hit", hit, 0);
    chk("rst_dout", dataOut, 0);
    chk("rst_busy", flushBusy, 0);
    chk("rst_wbv", wbValid, 0);
    cyc(); cyc();
    @(negedge clk) rst = 1'b1;

    // empty cache lookup
    req(1, 0, 0, 4'h0, 4'b0000, 32'h0);
    chk("r0_hit", hit, 0);
    chk("r0_dout", dataOut, 0);
    chk("r0_dirty", dirtyBit, 0);
    chk("r0_vict", victimAddr, 4'b0000);

    // fill, byte write, read back
    req(0, 0, 1, 4'h0, 4'b0000, 32'hFFFFFFFF);
    chk("fill_hit", hit, 0);
    req(0, 1, 0, 4'b0011, 4'b0000, 32'hAAAAAAAA);
    chk("wr_hit", hit, 1);
    chk("wr_dout", dataOut, 0);
    req(1, 0, 0, 4'h0, 4'b0000, 32'h0);
    chk("rd_hit", hit, 1);
    chk("rd_dout", dataOut, 32'hFFFFAAAA);
    chk("rd_dirty", dirtyBit, 0);
    cyc();
    chk("hold_dout", dataOut, 32'hFFFFAAAA);

    // LRU victim
    req(0, 0, 1, 4'h0, 4'b0010, 32'h12345678);
    req(1, 0, 0, 4'h0, 4'b0000, 32'h0);
    req(1, 0, 0, 4'h0, 4'b0100, 32'h0);
    chk("lru_hit", hit, 0);
    chk("lru_vict", victimAddr, 4'b0010);
    chk("lru_dirty", dirtyBit, 0);
    req(1, 0, 0, 4'h0, 4'b0010, 32'h0);
    chk("w1_dout", dataOut, 32'h12345678);
    req(1, 0, 0, 4'h0, 4'b0100, 32'h0);
    chk("lru2_vict", victimAddr, 4'b0000);
    chk("lru2_dirty", dirtyBit, 1);

    // simultaneous requests: fill wins
    req(1, 1, 1, 4'b0001, 4'b0111, 32'hCAFEF00D);
    chk("prec_hit", hit, 0);
    req(1, 0, 0, 4'h0, 4'b0111, 32'h0);
    chk("prec_rhit", hit, 1);
    chk("prec_dout", dataOut, 32'hCAFEF00D);

`ifdef DCACHE_FLUSH_EN
    // flush with stalled write-back
    @(negedge clk) flushReq = 1'b1;
    cyc();
    flushReq = 1'b0;
    chk("fl_busy", flushBusy, 1);
    wait_wb();
    chk("fl_wbaddr", wbAddr, 4'b0000);
    chk("fl_wbdata", wbData, 32'hFFFFAAAA);
    a0 = wbAddr; d0 = wbData;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memWen = 1'b1; blockAddr = 4'b0000;
      dataIn = 32'h0; flushReq = 1'b1;
      cyc();
      memWen = 1'b0; flushReq = 1'b0;
      chk("fl_hold_v", wbValid, 1);
      chk("fl_hold_a", wbAddr, a0);
      chk("fl_hold_d", wbData, d0);
    end
    @(negedge clk) wbReady = 1'b1;
    cyc();
    wbReady = 1'b0;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (flushDone) n_done++;
      if (!flushBusy) break;
      cyc();
    end
    chk("fl_idle", flushBusy, 0);
    chk("fl_done_n", n_done, 1);
    req(1, 0, 0, 4'h0, 4'b0100, 32'h0);
    chk("fl_vict", victimAddr, 4'b0000);
    chk("fl_clean", dirtyBit, 0);
    req(1, 0, 0, 4'h0, 4'b0000, 32'h0);
    chk("fl_keep_hit", hit, 1);
    chk("fl_keep_d", dataOut, 32'hFFFFAAAA);

    // reset during write-back wait
    req(0, 1, 0, 4'b1111, 4'b0000, 32'h55555555);
    @(negedge clk) flushReq = 1'b1;
    cyc();
    flushReq = 1'b0;
    wait_wb();
    #2 rst = 1'b0;
    #1;
    chk("ab_busy", flushBusy, 0);
    chk("ab_wbv", wbValid, 0);
    n_done = 0;
    cyc();
    if (flushDone) n_done++;
    @(negedge clk) rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (flushDone) n_done++;
    end
    chk("ab_done_n", n_done, 0);
`else
    // flush hardware absent
    @(negedge clk) flushReq = 1'b1;
    wbReady = 1'b1;
    cyc();
    cyc();
    flushReq = 1'b0;
    wbReady = 1'b0;
    chk("nf_busy", flushBusy, 0);
    chk("nf_done", flushDone, 0);
    chk("nf_wbv", wbValid, 0);
    chk("nf_wba", wbAddr, 0);
    chk("nf_wbd", wbData, 0);
    @(negedge clk) rst = 1'b0;
    cyc();
    @(negedge clk) rst = 1'b1;
`endif
    req(1, 0, 0, 4'h0, 4'b0000, 32'h0);
    chk("post_rst_hit", hit, 0);

    // write beats read in the same cycle
    req(0, 0, 1, 4'h0, 4'b0000, 32'h01020304);
    req(1, 1, 0, 4'b1000, 4'b0000, 32'hAB000000);
    chk("wr_rd_hit", hit, 1);
    chk("wr_rd_dout", dataOut, 0);
    req(1, 0, 0, 4'h0, 4'b0000, 32'h0);
    chk("wr_rd_data", dataOut, 32'hAB020304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
